// File: rtl/tt_um_addon.sv
// Euclidean magnitude |(X,Y)| = floor(sqrt(X^2+Y^2)), saturated to 8 bits, via a
// 1-cycle square stage and a 9-cycle bit-serial root. Define SQRT_ROUND_EN to round to nearest.
module tt_um_addon (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SQUARE = 2'd1;
  localparam logic [1:0] ROOT   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        busy;
  logic [7:0]  x_q, x_d, y_q, y_d, uo_q, uo_d;
  logic [17:0] s_q, s_d;
  logic [9:0]  rem_q, rem_d;
  logic [8:0]  root_q, root_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ld_op, do_square, do_root, last_step;

  logic [15:0] xx, yy;
  logic [16:0] sq_sum;
  logic [11:0] rem_sh, trial;
  logic [9:0]  rem_nx;
  logic [8:0]  root_nx;
  logic [9:0]  q_adj;

  // State register; busy mirrors "next state is not IDLE" so it is a true flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = ena ? SQUARE : IDLE;
      SQUARE:  state_d = ROOT;
      ROOT:    state_d = (cnt_q == 4'd8) ? IDLE : ROOT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ld_op     = (state_q == IDLE) && ena;
    do_square = (state_q == SQUARE);
    do_root   = (state_q == ROOT);
    last_step = do_root && (cnt_q == 4'd8);
  end

  assign xx     = x_q * x_q;
  assign yy     = y_q * y_q;
  assign sq_sum = {1'b0, xx} + {1'b0, yy};

  // Restoring root: bring down the next radicand bit pair, try subtracting 4*root+1.
  always_comb begin
    rem_sh = {rem_q, s_q[17:16]};
    trial  = {1'b0, root_q, 2'b01};
    if (rem_sh >= trial) begin
      rem_nx  = 10'(rem_sh - trial);
      root_nx = {root_q[7:0], 1'b1};
    end else begin
      rem_nx  = rem_sh[9:0];
      root_nx = {root_q[7:0], 1'b0};
    end
  end

`ifdef SQRT_ROUND_EN
  assign q_adj = {1'b0, root_nx} + ((rem_nx > {1'b0, root_nx}) ? 10'd1 : 10'd0);
`else
  assign q_adj = {1'b0, root_nx};
`endif

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    s_d    = s_q;
    rem_d  = rem_q;
    root_d = root_q;
    cnt_d  = cnt_q;
    uo_d   = uo_q;
    if (ld_op) begin
      x_d = ui_in;
      y_d = uio_in;
    end
    if (do_square) begin
      s_d    = {1'b0, sq_sum};
      rem_d  = '0;
      root_d = '0;
      cnt_d  = '0;
    end
    if (do_root) begin
      s_d    = {s_q[15:0], 2'b00};
      rem_d  = rem_nx;
      root_d = root_nx;
      cnt_d  = cnt_q + 4'd1;
    end
    if (last_step) uo_d = (q_adj > 10'd255) ? 8'hFF : q_adj[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      s_q    <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      uo_q   <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      s_q    <= s_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_d;
      uo_q   <= uo_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
endmodule

// File: tb/tb_tt_um_addon.sv
// Scoreboard bench for tt_um_addon: starts are queued with a plain-arithmetic
// magnitude model, a negedge monitor pops and compares when busy falls.
module tb_tt_um_addon;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'd0, uio_in = 8'd0;
  logic [7:0] uo_out, uio_out, uio_oe;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int last_res = 0;
  int bcnt = 0;
  logic prev_busy = 1'b0;

  tt_um_addon dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endfunction

  function automatic int model(int x, int y);
    int s, q;
    s = x * x + y * y;
    q = 0;
    while ((q + 1) * (q + 1) <= s) q++;
`ifdef SQRT_ROUND_EN
    if (s - q * q > q) q++;
`endif
    if (q > 255) q = 255;
    return q;
  endfunction

  // Start rule: ena sampled high while the block is idle launches an operation.
  always @(posedge clk)
    if (rst_n && ena && !dut.busy) exp_q.push_back(model(int'(ui_in), int'(uio_in)));

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      bcnt      = 0;
      last_res  = 0;
    end else begin
      chk("uio_out", int'(uio_out), 0);
      chk("uio_oe", int'(uio_oe), 0);
      if (dut.busy) bcnt++;
      if (prev_busy && !dut.busy) begin
        chk("busy_len", bcnt, 10);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL result got=%0d want=<none queued>", uo_out);
        end else begin
          last_res = exp_q.pop_front();
          chk("result", int'(uo_out), last_res);
        end
        bcnt = 0;
      end else begin
        chk("uo_hold", int'(uo_out), last_res);
      end
      prev_busy = dut.busy;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (dut.busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (dut.busy) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout got=busy want=idle");
    end
  endtask

  task automatic start_op(int x, int y, bit poke);
    wait_idle();
    ena = 1'b1;
    ui_in = 8'(x);
    uio_in = 8'(y);
    @(negedge clk);
    ena = 1'b0;
    ui_in = 8'($urandom);
    uio_in = 8'($urandom);
    if (poke) begin
      repeat (2) @(negedge clk);
      ena = 1'b1;
      ui_in = 8'd1;
      uio_in = 8'd1;
      @(negedge clk);
      ena = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || dut.busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(dut.busy), 0);
    chk("rst_uo", int'(uo_out), 0);
    chk("rst_uio_out", int'(uio_out), 0);
    chk("rst_uio_oe", int'(uio_oe), 0);
    #2 rst_n = 1'b1;

    start_op(3, 4, 0);
    start_op(2, 3, 0);
    start_op(255, 255, 0);
    start_op(0, 0, 0);
    start_op(180, 180, 1);
    start_op(7, 24, 0);
    drain();

    // Abort mid-operation: uo_out must drop to 0 at once.
    start_op(9, 9, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(dut.busy), 0);
    chk("abort_uo", int'(uo_out), 0);
    exp_q.delete();
    last_res = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    start_op(6, 8, 0);
    drain();

    // ena held high: back-to-back operations with one idle cycle between.
    wait_idle();
    ena = 1'b1;
    ui_in = 8'd5;
    uio_in = 8'd12;
    repeat (40) @(negedge clk);
    ena = 1'b0;
    drain();

    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      start_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), ($urandom % 4) == 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
